// File: rtl/pic_irq_controller_if.sv
// rtl/pic_irq_controller_if.sv - register port and CPU acknowledge/EOI bundle for pic_irq_controller
interface pic_irq_controller_if #(
  parameter int NUM_IRQ  = 16,
  parameter int ID_W     = 4,
  parameter int VECTOR_W = 8
);
  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic [NUM_IRQ-1:0]  cfg_wdata;
  logic [NUM_IRQ-1:0]  cfg_rdata;
  logic                int_req;
  logic                int_ack;
  logic                eoi_valid;
  logic                eoi_specific;
  logic [ID_W-1:0]     eoi_id;
  logic [VECTOR_W-1:0] vector;
  logic                vector_valid;
  logic                spurious;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, eoi_valid, eoi_specific, eoi_id,
    input  cfg_rdata, int_req, vector, vector_valid, spurious
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, eoi_valid, eoi_specific, eoi_id,
    output cfg_rdata, int_req, vector, vector_valid, spurious
  );
endinterface

// File: rtl/pic_irq_controller.sv
// rtl/pic_irq_controller.sv - parametrised 8259A-style controller with fully nested fixed/rotating priority
module pic_irq_controller #(
  parameter int                  NUM_IRQ     = 16,
  parameter int                  ID_W        = 4,
  parameter int                  VECTOR_W    = 8,
  parameter logic [VECTOR_W-1:0] VECTOR_BASE = 8'h20
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  pic_irq_controller_if.slave bus
);
  localparam logic [VECTOR_W-1:0] SPUR_VEC = VECTOR_BASE + VECTOR_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] sync1, sync2, sync3;
  logic [NUM_IRQ-1:0] imr, trig, irr, isr;
  logic               rotate_en, auto_eoi;
  logic [ID_W-1:0]    ptr;

  logic [NUM_IRQ-1:0] pend, win_mask, eoi_mask, trig_fall, irr_n, isr_n;
  logic [ID_W-1:0]    idx, win_id, isr_id, eoi_ch, ptr_n;
  int                 win_pos, isr_pos;
  logic               win_valid, eoi_hit, ack_hit;

  // Index 'off' places after 'base' in the circular channel order.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IRQ) s = s - NUM_IRQ;
    return ID_W'(s);
  endfunction

  // Scanning from lowest to highest priority leaves the highest-priority hit in place.
  always_comb begin
    pend    = irr & ~imr;
    idx     = '0;
    win_id  = '0;
    isr_id  = '0;
    win_pos = NUM_IRQ;
    isr_pos = NUM_IRQ;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      idx = wrap_inc(ptr, j);
      if (pend[idx]) begin
        win_id  = idx;
        win_pos = j;
      end
      if (isr[idx]) begin
        isr_id  = idx;
        isr_pos = j;
      end
    end
    win_valid = (win_pos < isr_pos);
  end

  always_comb begin
    eoi_hit = 1'b0;
    eoi_ch  = '0;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        if (int'(bus.eoi_id) < NUM_IRQ && isr[bus.eoi_id]) begin
          eoi_hit = 1'b1;
          eoi_ch  = bus.eoi_id;
        end
      end else if (isr_pos < NUM_IRQ) begin
        eoi_hit = 1'b1;
        eoi_ch  = isr_id;
      end
    end

    ack_hit  = bus.int_ack && win_valid;
    win_mask = '0;
    win_mask[win_id] = 1'b1;
    eoi_mask = '0;
    eoi_mask[eoi_ch] = 1'b1;

    // EOI clears against the pre-ack ISR, then the ack set is OR-ed on top.
    isr_n = (isr & ~(eoi_hit ? eoi_mask : '0)) | ((ack_hit && !auto_eoi) ? win_mask : '0);

    trig_fall = (bus.cfg_we && bus.cfg_addr == 3'd1) ? (trig & ~bus.cfg_wdata) : '0;
    irr_n = (trig & sync2)
          | (~trig & ((irr & ~(ack_hit ? win_mask : '0)) | (sync2 & ~sync3)));
    irr_n = irr_n & ~trig_fall;

    ptr_n = ptr;
    if (ack_hit && auto_eoi && rotate_en) ptr_n = wrap_inc(win_id, 1);
    if (eoi_hit && rotate_en) ptr_n = wrap_inc(eoi_ch, 1);
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      3'd0:    bus.cfg_rdata = imr;
      3'd1:    bus.cfg_rdata = trig;
      3'd2:    bus.cfg_rdata[1:0] = {auto_eoi, rotate_en};
      3'd3:    bus.cfg_rdata = irr;
      3'd4:    bus.cfg_rdata = isr;
      default: bus.cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1            <= '0;
      sync2            <= '0;
      sync3            <= '0;
      imr              <= '1;
      trig             <= '0;
      irr              <= '0;
      isr              <= '0;
      rotate_en        <= 1'b0;
      auto_eoi         <= 1'b0;
      ptr              <= '0;
      bus.int_req      <= 1'b0;
      bus.vector       <= '0;
      bus.vector_valid <= 1'b0;
      bus.spurious     <= 1'b0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      sync3 <= sync2;
      irr   <= irr_n;
      isr   <= isr_n;
      ptr   <= ptr_n;
      bus.int_req <= win_valid;
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          3'd0:    imr <= bus.cfg_wdata;
          3'd1:    trig <= bus.cfg_wdata;
          3'd2:    {auto_eoi, rotate_en} <= bus.cfg_wdata[1:0];
          default: ;
        endcase
      end
      bus.vector_valid <= bus.int_ack;
      bus.spurious     <= bus.int_ack && !win_valid;
      if (bus.int_ack) bus.vector <= ack_hit ? (VECTOR_BASE + VECTOR_W'(win_id)) : SPUR_VEC;
    end
  end
endmodule

// File: doc/pic_irq_controller.md
Name: pic_irq_controller

Overview:
- Parametrised, fully synchronous successor of the 8-input 8259A-style controller.
- Supports NUM_IRQ request lines with per-channel mask and per-channel edge/level trigger.
- Priority is fully nested, either fixed or rotating; supports normal EOI or auto-EOI.
- Uses a pulse-based acknowledge/vector handshake to the CPU-side interface and a simple register port for configuration and status.

Parameters:
- NUM_IRQ, 16, number of request channels (2..32); channel 0 is highest priority at reset.
- ID_W, 4, width of the channel index; must equal clog2(NUM_IRQ).
- VECTOR_W, 8, width of the returned vector.
- VECTOR_BASE, 8'h20, vector for channel 0; channel k returns VECTOR_BASE+k, truncated to VECTOR_W.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw request lines, asynchronous to clock.
- cfg_we  in  1  register write strobe, one cycle.
- cfg_addr  in  3  register select: 0 IMR, 1 TRIG (1=level, 0=edge), 2 CTRL (bit0 rotate_en, bit1 auto_eoi), 3 IRR (read-only), 4 ISR (read-only).
- cfg_wdata  in  NUM_IRQ  write data.
- cfg_rdata  out  NUM_IRQ  combinational read of the addressed register; unused addresses and upper CTRL bits read 0.
- int_req  out  1  registered interrupt request to CPU.
- int_ack  in  1  acknowledge pulse, one cycle.
- eoi_valid  in  1  end-of-interrupt command pulse.
- eoi_specific  in  1  1 = specific EOI on eoi_id; 0 = non-specific.
- eoi_id  in  ID_W  channel for specific EOI.
- vector  out  VECTOR_W  vector for the acknowledged interrupt.
- vector_valid  out  1  one-cycle pulse qualifying vector.
- spurious  out  1  qualifies vector_valid when no channel was pending at acknowledge.

Behaviour:
- Reset values: IMR all 1 (all masked); TRIG 0; CTRL 0; IRR 0; ISR 0; priority pointer 0; sync flops 0; int_req, vector, vector_valid, spurious all 0.
- Input path: 2-flop synchroniser per channel.
  - Edge channels: IRR bit set on a synchronised 0->1 transition; held until acknowledged or the channel is switched to level mode.
  - Level channels: IRR bit follows the synchronised level each cycle.
  - Masked channels still update IRR but never compete.
- Priority resolution, combinational from IRR & ~IMR, ISR and pointer P:
  - Channel order is P, P+1, ..., wrapping mod NUM_IRQ.
  - The winner is the first unmasked pending channel in that order.
  - The winner is valid only if it precedes every set ISR bit in the same order (fully nested).
- int_req is a register equal to winner-valid, i.e. one cycle after IRR/ISR/IMR change.
  - Latency: irq_in high sampled at edge k -> int_req high after edge k+3, given unmasked and no higher ISR.
- Acknowledge, int_ack=1 sampled at an edge:
  - With a valid winner w: ISR[w] set, unless auto_eoi; IRR[w] cleared for edge channels; vector=VECTOR_BASE+w; vector_valid=1 for exactly the next cycle; spurious=0; int_req drops the cycle after.
  - If auto_eoi and rotate_en, P <= w+1 mod NUM_IRQ.
  - No valid winner: vector=VECTOR_BASE+NUM_IRQ-1, spurious=1, vector_valid=1; ISR and IRR unchanged.
  - int_ack held longer than one cycle is treated as repeated acknowledges.
- EOI, eoi_valid=1:
  - Non-specific: clears the first set ISR bit in current priority order.
  - Specific: clears ISR[eoi_id]; eoi_id >= NUM_IRQ is ignored.
  - No ISR bit to clear: no effect, and P is unchanged.
  - If rotate_en and a bit c was cleared: P <= c+1 mod NUM_IRQ, so c becomes lowest priority.
- Simultaneous ack and EOI in one cycle: the EOI clear is evaluated on pre-ack ISR, then the ack set is applied. If both target the same bit, the set wins.
  - If both would move P, the EOI update wins.
- Config writes take effect at the next edge.
  - Writing TRIG bit 1->0 clears that IRR bit.
  - Writing IRR or ISR addresses has no effect.
- Reset asserted mid-handshake: all state returns to reset values immediately; a pending vector_valid is lost.

Test Plan:
- Reset, IMR=0, TRIG=0, pulse irq_in[5] -> int_req high 3 edges after sampling; int_ack -> vector=8'h25, vector_valid for 1 cycle, ISR=0x0020, IRR[5]=0, int_req low.
- Fixed priority: irq 3 and 9 pending together -> first ack vector 8'h23. While ISR[3] is set, irq 1 pending -> int_req re-asserts (nested), ack vector 8'h21. Non-specific EOI clears ISR[1], then a second EOI clears ISR[3]; only then is irq 9 delivered, vector 8'h29.
- Rotation: CTRL=1, service channel 4 then specific EOI id=4 -> P=5. Pending 2 and 7 -> ack vector 8'h27.
- Masking and level: TRIG[0]=1, IMR[0]=1 with irq_in[0] held high -> IRR[0]=1, int_req=0. Clear IMR[0] -> int_req high. Ack and auto_eoi=1 -> ISR stays 0, int_req re-asserts while level held.
- Spurious and corner cases: int_ack with int_req=0 -> vector 8'h2F, spurious=1, ISR unchanged. EOI with ISR=0 -> no change. Ack and EOI same cycle on the same bit -> ISR bit remains set.
- Reset asserted during vector_valid -> all outputs 0 asynchronously and IMR=all 1.
